// File: rtl/serial_func_unit_v.sv
// serial_func_unit_v
// Bit-serial four-function unit. Two WIDTH-bit operands are processed one
// bit per clock, LSB first, through a single-bit function cell. A registered
// carry links the bits for the add code. A start/done handshake frames each
// operation. Results are registered and held until the next completion.
module serial_func_unit_v #(
  parameter int WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic [1:0]       i_code,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result,
  output logic             o_cout,
  output logic             o_zero
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // Single-bit function cell shared by all four codes.
  function automatic logic cell_f(input logic [1:0] code, input logic a,
                                  input logic b, input logic c);
    logic f;
    case (code)
      2'b00:   f = a ^ b ^ c;
      2'b01:   f = ~(a & b & c);
      2'b10:   f = ~(a | b | c);
      2'b11:   f = ~(a ^ b ^ c);
      default: f = 1'b0;
    endcase
    return f;
  endfunction

  // Majority of three, the carry out of a full adder.
  function automatic logic cell_carry(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  state_t           state_r;
  state_t           state_nxt_s;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic [WIDTH-1:0] res_nxt_s;
  logic [1:0]       code_r;
  logic             c_r;
  logic [CW-1:0]    cnt_r;
  logic             f_s;
  logic             carry_nxt_s;
  logic             last_s;
  logic [WIDTH-1:0] result_r;
  logic             cout_r;
  logic             zero_r;
  logic             done_r;
  logic             busy_r;

  // Current bit of the function cell and the carry it would produce.
  always_comb begin
    f_s         = cell_f(code_r, a_sh_r[0], b_sh_r[0], c_r);
    carry_nxt_s = cell_carry(a_sh_r[0], b_sh_r[0], c_r);
    last_s      = (state_r == ST_RUN) && (cnt_r == LAST_BIT);
  end

  // The new bit enters the result shift register from the MSB side.
  if (WIDTH == 1) begin : g_w1
    assign res_nxt_s = f_s;
  end else begin : g_wn
    assign res_nxt_s = {f_s, res_sh_r[WIDTH-1:1]};
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: IDLE -> RUN -> DONE -> IDLE; start is only seen in IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Operand capture, bit-serial datapath and registered result outputs.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      res_sh_r <= {WIDTH{1'b0}};
      code_r   <= 2'b00;
      c_r      <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      result_r <= {WIDTH{1'b0}};
      cout_r   <= 1'b0;
      zero_r   <= 1'b1;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      done_r <= 1'b0;
      busy_r <= (state_nxt_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (i_start) begin
            a_sh_r <= i_a;
            b_sh_r <= i_b;
            code_r <= i_code;
            c_r    <= i_cin;
            cnt_r  <= {CW{1'b0}};
          end
        end
        ST_RUN: begin
          a_sh_r   <= a_sh_r >> 1'b1;
          b_sh_r   <= b_sh_r >> 1'b1;
          res_sh_r <= res_nxt_s;
          cnt_r    <= cnt_r + CW'(1);
          if (code_r == 2'b00) begin
            c_r <= carry_nxt_s;
          end
          // Final bit: publish the completed result straight into the
          // output registers so they are valid during the DONE cycle.
          if (last_s) begin
            result_r <= res_nxt_s;
            cout_r   <= (code_r == 2'b00) ? carry_nxt_s : 1'b0;
            zero_r   <= (res_nxt_s == {WIDTH{1'b0}});
            done_r   <= 1'b1;
          end
        end
        ST_DONE: begin
          done_r <= 1'b0;
        end
        default: begin
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy   = busy_r;
  assign o_done   = done_r;
  assign o_result = result_r;
  assign o_cout   = cout_r;
  assign o_zero   = zero_r;

endmodule

// File: tb/tb_serial_func_unit_v.sv
// Testbench for serial_func_unit_v: directed WIDTH=8 vectors plus a
// WIDTH=1 / WIDTH=33 sweep against an arithmetic reference.
module tb_serial_func_unit_v;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  sel;          // 0: WIDTH=1, 1: WIDTH=8, 2: WIDTH=33
  logic [63:0] a_in;
  logic [63:0] b_in;
  logic        cin_in;
  logic [1:0]  code_in;

  logic        busy1, done1, cout1, zero1;
  logic [0:0]  res1;
  logic        busy8, done8, cout8, zero8;
  logic [7:0]  res8;
  logic        busy33, done33, cout33, zero33;
  logic [32:0] res33;

  logic        busy_m, done_m, cout_m, zero_m;
  logic [63:0] res_m;

  int n_checks = 0;
  int n_errors = 0;

  serial_func_unit_v #(.WIDTH(1)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_start(start && (sel == 2'd0)),
    .i_a(a_in[0:0]), .i_b(b_in[0:0]), .i_cin(cin_in), .i_code(code_in),
    .o_busy(busy1), .o_done(done1), .o_result(res1), .o_cout(cout1), .o_zero(zero1));

  serial_func_unit_v #(.WIDTH(8)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_start(start && (sel == 2'd1)),
    .i_a(a_in[7:0]), .i_b(b_in[7:0]), .i_cin(cin_in), .i_code(code_in),
    .o_busy(busy8), .o_done(done8), .o_result(res8), .o_cout(cout8), .o_zero(zero8));

  serial_func_unit_v #(.WIDTH(33)) dut33 (
    .i_clk(clk), .i_rst(rst), .i_start(start && (sel == 2'd2)),
    .i_a(a_in[32:0]), .i_b(b_in[32:0]), .i_cin(cin_in), .i_code(code_in),
    .o_busy(busy33), .o_done(done33), .o_result(res33), .o_cout(cout33), .o_zero(zero33));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Route the selected instance's outputs to common observation signals.
  always_comb begin
    busy_m = busy8; done_m = done8; cout_m = cout8; zero_m = zero8;
    res_m  = {56'd0, res8};
    case (sel)
      2'd0: begin
        busy_m = busy1; done_m = done1; cout_m = cout1; zero_m = zero1;
        res_m  = {63'd0, res1};
      end
      2'd2: begin
        busy_m = busy33; done_m = done33; cout_m = cout33; zero_m = zero33;
        res_m  = {31'd0, res33};
      end
      default: ;
    endcase
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Arithmetic reference: add as a true sum, logic codes as whole-word ops.
  task automatic ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                           input logic cin, input logic [1:0] code,
                           output logic [63:0] res, output logic cout);
    logic [64:0] sum;
    logic [63:0] mask;
    logic [63:0] c;
    mask = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
    c    = cin ? mask : 64'd0;
    a    = a & mask;
    b    = b & mask;
    sum  = {1'b0, a} + {1'b0, b} + {64'd0, cin};
    cout = 1'b0;
    case (code)
      2'b00: begin res = sum[63:0] & mask; cout = sum[w]; end
      2'b01: res = ~(a & b & c) & mask;
      2'b10: res = ~(a | b | c) & mask;
      default: res = ~(a ^ b ^ c) & mask;
    endcase
  endtask

  // One complete operation on the selected instance with latency check.
  task automatic run_op(input string tag, input int w, input logic [63:0] a,
                        input logic [63:0] b, input logic cin, input logic [1:0] code,
                        input logic [63:0] exp_res, input logic exp_cout);
    int n;
    @(negedge clk);
    a_in = a; b_in = b; cin_in = cin; code_in = code; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    a_in = ~a; b_in = ~b; cin_in = ~cin; code_in = ~code;
    check({tag, "_busy"}, {63'd0, busy_m}, 64'd1);
    n = 0;
    do begin
      @(posedge clk);
      @(negedge clk);
      n++;
    end while (!done_m && n < w + 4);
    check({tag, "_latency"}, 64'(n + 1), 64'(w + 1));
    check({tag, "_result"}, res_m, exp_res);
    check({tag, "_cout"}, {63'd0, cout_m}, {63'd0, exp_cout});
    check({tag, "_zero"}, {63'd0, zero_m}, {63'd0, (exp_res == 64'd0)});
    @(posedge clk);
    @(negedge clk);
    check({tag, "_done_low"}, {63'd0, done_m}, 64'd0);
    check({tag, "_idle"}, {63'd0, busy_m}, 64'd0);
  endtask

  initial begin
    logic [63:0] ra, rb, er;
    logic        ec;
    int          cnt, last_k, low_cnt;

    rst = 1'b1; start = 1'b0; sel = 2'd1;
    a_in = 64'd0; b_in = 64'd0; cin_in = 1'b0; code_in = 2'b00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy_m}, 64'd0);
    check("rst_done", {63'd0, done_m}, 64'd0);
    check("rst_result", res_m, 64'd0);
    check("rst_cout", {63'd0, cout_m}, 64'd0);
    check("rst_zero", {63'd0, zero_m}, 64'd1);
    rst = 1'b0;

    // Hand-computed WIDTH=8 vectors.
    run_op("add_ovf", 8, 64'hFF, 64'h01, 1'b0, 2'b00, 64'h00, 1'b1);
    run_op("add_cin", 8, 64'h3C, 64'h45, 1'b1, 2'b00, 64'h82, 1'b0);
    run_op("nand3",   8, 64'hF0, 64'hCC, 1'b1, 2'b01, 64'h3F, 1'b0);
    run_op("nor3_c0", 8, 64'hF0, 64'h0C, 1'b0, 2'b10, 64'h03, 1'b0);
    run_op("nor3_c1", 8, 64'hF0, 64'h0C, 1'b1, 2'b10, 64'h00, 1'b0);
    run_op("xnor3",   8, 64'hAA, 64'h0F, 1'b0, 2'b11, 64'h5A, 1'b0);

    // Extra start pulses at cycles 3 and 9 are ignored.
    @(negedge clk);
    a_in = 64'h12; b_in = 64'h34; cin_in = 1'b0; code_in = 2'b00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_in = 64'hFF; b_in = 64'hFF;
    cnt = 0;
    for (int k = 1; k <= 14; k++) begin
      start = (k == 3) || (k == 9);
      @(posedge clk);
      @(negedge clk);
      if (done_m) cnt++;
      if (k == 1) check("hs_hold_result", res_m, 64'h5A);
    end
    start = 1'b0;
    check("hs_done_count", 64'(cnt), 64'd1);
    check("hs_result", res_m, 64'h46);
    check("hs_idle", {63'd0, busy_m}, 64'd0);

    // Start held high: one op every 10 cycles, busy low one cycle between.
    @(negedge clk);
    a_in = 64'hF0; b_in = 64'hCC; cin_in = 1'b1; code_in = 2'b01; start = 1'b1;
    @(posedge clk);
    cnt = 0; last_k = -1; low_cnt = 0;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (!busy_m) low_cnt++;
      if (done_m) begin
        if (last_k >= 0) check("b2b_gap", 64'(k - last_k), 64'd10);
        last_k = k;
        cnt++;
      end
    end
    start = 1'b0;
    check("b2b_done_count", 64'(cnt), 64'd3);
    check("b2b_busy_low", 64'(low_cnt), 64'd3);
    check("b2b_result", res_m, 64'h3F);
    cnt = 0;
    while (busy_m && cnt < 20) begin
      @(posedge clk);
      @(negedge clk);
      cnt++;
    end
    check("b2b_drain", {63'd0, busy_m}, 64'd0);

    // Asynchronous reset four cycles into RUN.
    @(negedge clk);
    a_in = 64'h3C; b_in = 64'h45; cin_in = 1'b1; code_in = 2'b00; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", {63'd0, busy_m}, 64'd0);
    check("mid_rst_done", {63'd0, done_m}, 64'd0);
    check("mid_rst_result", res_m, 64'd0);
    check("mid_rst_zero", {63'd0, zero_m}, 64'd1);
    cnt = 0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_m) cnt++;
    end
    rst = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (done_m) cnt++;
    end
    check("mid_rst_no_done", 64'(cnt), 64'd0);
    run_op("after_rst", 8, 64'h3C, 64'h45, 1'b1, 2'b00, 64'h82, 1'b0);

    // WIDTH=1: every code and cin value.
    sel = 2'd0;
    for (int i = 0; i < 8; i++) begin
      ra = 64'($urandom_range(1, 0));
      rb = 64'($urandom_range(1, 0));
      ref_model(1, ra, rb, i[0], i[2:1], er, ec);
      run_op("w1", 1, ra, rb, i[0], i[2:1], er, ec);
    end

    // WIDTH=33: every code and cin value with random operands.
    sel = 2'd2;
    for (int i = 0; i < 8; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i == 1) begin ra = 64'h1_FFFF_FFFF; rb = 64'd0; end
      ref_model(33, ra, rb, i[0], i[2:1], er, ec);
      run_op("w33", 33, ra, rb, i[0], i[2:1], er, ec);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
